// File: rtl/fp_norm_round.sv
// Floating-point normalize-and-round back end: a two-stage valid/ready pipeline that
// turns a double-width product significand and exponent into a packed IEEE-style result.
module fp_norm_round #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sign,
  input  logic [EXP_W+1:0]          in_exp,
  input  logic [2*(MAN_W+1)-1:0]    in_sig,
  input  logic [2:0]                in_rm,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+MAN_W:0]      out_result,
  output logic [2:0]                out_flags
);

  localparam int PROD_W = 2 * (MAN_W + 1);
  localparam int EW     = EXP_W + 8;
  localparam int PW     = $clog2(PROD_W);
  localparam int SH_MAX = MAN_W + 2;
  localparam int SH_W   = $clog2(SH_MAX + 1);
  localparam int RES_W  = 1 + EXP_W + MAN_W;

  localparam logic signed [EW-1:0] EXP_ZERO = '0;
  localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
  localparam logic signed [EW-1:0] EXP_INF  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] SH_SAT   = EW'(SH_MAX);

  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  // ---------------- handshake ----------------
  logic s1_valid_reg;
  logic out_valid_reg;
  logic s2_ready;
  logic in_fire;

  assign s2_ready = !out_valid_reg || out_ready;
  assign in_ready = !s1_valid_reg || s2_ready;
  assign in_fire  = in_valid && in_ready;

  // ---------------- S1: normalize ----------------
  logic [PW-1:0]          lead_pos;
  logic signed [EW-1:0]   norm_exp;
  logic [PROD_W-1:0]      norm_sig;

  always_comb begin
    lead_pos = '0;
    for (int i = 0; i < PROD_W; i++) begin
      if (in_sig[i]) lead_pos = PW'(i);
    end
  end

  // The binary point sits below bit PROD_W-2, so a leading one there means unscaled.
  assign norm_exp = EW'($signed(in_exp)) + $signed(EW'(lead_pos)) - EW'(PROD_W - 2);
  assign norm_sig = in_sig << (PW'(PROD_W - 1) - lead_pos);

  logic                   s1_sign_reg;
  logic signed [EW-1:0]   s1_exp_reg;
  logic [PROD_W-1:0]      s1_sig_reg;
  logic [2:0]             s1_rm_reg;
  logic                   s1_zero_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_sign_reg  <= 1'b0;
      s1_exp_reg   <= '0;
      s1_sig_reg   <= '0;
      s1_rm_reg    <= '0;
      s1_zero_reg  <= 1'b0;
    end else begin
      if (in_ready) s1_valid_reg <= in_valid;
      if (in_fire) begin
        s1_sign_reg <= in_sign;
        s1_exp_reg  <= norm_exp;
        s1_sig_reg  <= norm_sig;
        s1_rm_reg   <= in_rm;
        s1_zero_reg <= (in_sig == '0);
      end
    end
  end

  // ---------------- S2: denormalize, round, pack ----------------
  logic                   tiny;
  logic signed [EW-1:0]   sh_full;
  logic [SH_W-1:0]        sh;
  logic [2*PROD_W-1:0]    wide;
  logic [PROD_W-1:0]      aligned;
  logic                   lost;
  logic                   lead_bit;
  logic [MAN_W-1:0]       frac;
  logic                   guard;
  logic                   sticky;
  logic                   inexact;
  logic                   inc;
  logic [MAN_W+1:0]       sum;
  logic signed [EW-1:0]   exp_r;
  logic                   of;
  logic                   uf;
  logic                   inf_sel;
  logic [RES_W-1:0]       res_next;
  logic [2:0]             flags_next;

  assign tiny    = (s1_exp_reg <= EXP_ZERO);
  assign sh_full = EXP_ONE - s1_exp_reg;

  always_comb begin
    sh = '0;
    if (tiny) begin
      if (sh_full > SH_SAT) sh = SH_W'(SH_MAX);
      else                  sh = sh_full[SH_W-1:0];
    end
  end

  // Shifting into a double-width word keeps every bit pushed out for the sticky OR.
  assign wide     = {s1_sig_reg, {PROD_W{1'b0}}} >> sh;
  assign aligned  = wide[2*PROD_W-1:PROD_W];
  assign lost     = |wide[PROD_W-1:0];
  assign lead_bit = aligned[PROD_W-1];
  assign frac     = aligned[PROD_W-2:MAN_W+1];
  assign guard    = aligned[MAN_W];
  assign sticky   = (|aligned[MAN_W-1:0]) | lost;
  assign inexact  = guard | sticky;

  always_comb begin
    case (s1_rm_reg)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = s1_sign_reg & inexact;
      RM_RUP:  inc = !s1_sign_reg & inexact;
      RM_RMM:  inc = guard;
      default: inc = guard & (sticky | frac[0]);
    endcase
  end

  assign sum = {1'b0, lead_bit, frac} + {{(MAN_W+1){1'b0}}, inc};

  always_comb begin
    case (s1_rm_reg)
      RM_RTZ:  inf_sel = 1'b0;
      RM_RDN:  inf_sel = s1_sign_reg;
      RM_RUP:  inf_sel = !s1_sign_reg;
      default: inf_sel = 1'b1;
    endcase
  end

  // A carry out of the significand leaves the fraction bits at zero on its own.
  always_comb begin
    exp_r = s1_exp_reg;
    if (tiny)                exp_r = sum[MAN_W] ? EXP_ONE : EXP_ZERO;
    else if (sum[MAN_W+1])   exp_r = s1_exp_reg + EXP_ONE;
  end

  assign of = !tiny && (exp_r >= EXP_INF);
  assign uf = tiny && inexact;

  always_comb begin
    res_next   = {s1_sign_reg, exp_r[EXP_W-1:0], sum[MAN_W-1:0]};
    flags_next = {1'b0, uf, inexact};
    if (s1_zero_reg) begin
      res_next   = {s1_sign_reg, {(EXP_W+MAN_W){1'b0}}};
      flags_next = 3'b000;
    end else if (of) begin
      flags_next = 3'b101;
      if (inf_sel) res_next = {s1_sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else         res_next = {s1_sign_reg, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
    end
  end

  logic [RES_W-1:0] out_result_reg;
  logic [2:0]       out_flags_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg  <= 1'b0;
      out_result_reg <= '0;
      out_flags_reg  <= '0;
    end else if (s2_ready) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_result_reg <= res_next;
        out_flags_reg  <= flags_next;
      end
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_result = out_result_reg;
  assign out_flags  = out_flags_reg;

endmodule

// File: tb/tb_fp_norm_round.sv
// Directed bench for fp_norm_round (EXP_W=8, MAN_W=23): vector table plus
// backpressure and mid-stream reset sequences.
module tb_fp_norm_round;

  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int PROD_W = 48;

  localparam logic [2:0] RNE = 3'd0;
  localparam logic [2:0] RTZ = 3'd1;
  localparam logic [2:0] RDN = 3'd2;
  localparam logic [2:0] RUP = 3'd3;
  localparam logic [2:0] RMM = 3'd4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_sign;
  logic [EXP_W+1:0]       in_exp;
  logic [PROD_W-1:0]      in_sig;
  logic [2:0]             in_rm;
  logic                   out_valid;
  logic                   out_ready;
  logic [EXP_W+MAN_W:0]   out_result;
  logic [2:0]             out_flags;

  always #5 clk = ~clk;

  fp_norm_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_sig(in_sig), .in_rm(in_rm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags)
  );

  typedef struct {
    string        name;
    logic [47:0]  sig;
    logic [9:0]   exp;
    logic         sign;
    logic [2:0]   rm;
    logic [31:0]  res;
    logic [2:0]   flags;
  } vec_t;

  int total = 0;
  int bad   = 0;
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, expv);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [47:0] s, input logic [9:0] e,
                              input logic sg, input logic [2:0] r, input logic [31:0] res,
                              input logic [2:0] f);
    vec_t v;
    v.name = n; v.sig = s; v.exp = e; v.sign = sg; v.rm = r; v.res = res; v.flags = f;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    in_sig  = v.sig;
    in_exp  = v.exp;
    in_sign = v.sign;
    in_rm   = v.rm;
  endtask

  // Entered and left at posedge+1 with the pipeline empty.
  task automatic send_one(input vec_t v);
    drive(v);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check({v.name, ":ready"}, 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({v.name, ":early"}, 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    check({v.name, ":valid"}, 64'(out_valid), 64'(1));
    check({v.name, ":result"}, 64'(out_result), 64'(v.res));
    check({v.name, ":flags"}, 64'(out_flags), 64'(v.flags));
    $display("vec %-14s sig=%h exp=%0d rm=%0d -> res=%h flags=%b", v.name, v.sig,
             $signed(v.exp), v.rm, out_result, out_flags);
    @(posedge clk); #1;
    check({v.name, ":drain"}, 64'(out_valid), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t bp[4];
    int   k;
    int   got;
    int   out_cyc[4];
    int   ghosts;

    vecs.push_back(mk("basic_2p25",  48'h900000000000, 10'sd127, 1'b0, RNE, 32'h40100000, 3'b000));
    vecs.push_back(mk("rne_tie_up",  48'h400000C00000, 10'sd127, 1'b0, RNE, 32'h3F800002, 3'b001));
    vecs.push_back(mk("rtz_trunc",   48'h400000C00000, 10'sd127, 1'b0, RTZ, 32'h3F800001, 3'b001));
    vecs.push_back(mk("of_rne",      48'h800000000000, 10'sd254, 1'b0, RNE, 32'h7F800000, 3'b101));
    vecs.push_back(mk("of_rtz",      48'h800000000000, 10'sd254, 1'b0, RTZ, 32'h7F7FFFFF, 3'b101));
    vecs.push_back(mk("of_rdn_pos",  48'h800000000000, 10'sd254, 1'b0, RDN, 32'h7F7FFFFF, 3'b101));
    vecs.push_back(mk("of_rup_neg",  48'h800000000000, 10'sd254, 1'b1, RUP, 32'hFF7FFFFF, 3'b101));
    vecs.push_back(mk("of_rdn_neg",  48'h800000000000, 10'sd254, 1'b1, RDN, 32'hFF800000, 3'b101));
    vecs.push_back(mk("max_exp",     48'h400000000000, 10'sd254, 1'b0, RNE, 32'h7F000000, 3'b000));
    vecs.push_back(mk("sub_half",    48'h400000000000, 10'sd0,   1'b0, RNE, 32'h00400000, 3'b000));
    vecs.push_back(mk("sub_quarter", 48'h400000000000, -10'sd1,  1'b0, RNE, 32'h00200000, 3'b000));
    vecs.push_back(mk("sub_min",     48'h400000000000, -10'sd22, 1'b0, RNE, 32'h00000001, 3'b000));
    vecs.push_back(mk("sub_tie_rne", 48'h400000000000, -10'sd23, 1'b0, RNE, 32'h00000000, 3'b011));
    vecs.push_back(mk("sub_tie_rup", 48'h400000000000, -10'sd23, 1'b0, RUP, 32'h00000001, 3'b011));
    vecs.push_back(mk("sub_flush",   48'h400000000000, -10'sd30, 1'b0, RNE, 32'h00000000, 3'b011));
    vecs.push_back(mk("zero_neg",    48'h000000000000, 10'sd100, 1'b1, RUP, 32'h80000000, 3'b000));
    vecs.push_back(mk("lsb_only",    48'h000000000001, 10'sd173, 1'b0, RNE, 32'h3F800000, 3'b000));
    vecs.push_back(mk("neg_rne",     48'h400000400000, 10'sd127, 1'b1, RNE, 32'hBF800000, 3'b001));
    vecs.push_back(mk("neg_rdn",     48'h400000400000, 10'sd127, 1'b1, RDN, 32'hBF800001, 3'b001));
    vecs.push_back(mk("neg_rup",     48'h400000400000, 10'sd127, 1'b1, RUP, 32'hBF800000, 3'b001));
    vecs.push_back(mk("neg_rmm",     48'h400000400000, 10'sd127, 1'b1, RMM, 32'hBF800001, 3'b001));
    vecs.push_back(mk("neg_rm5",     48'h400000400000, 10'sd127, 1'b1, 3'd5, 32'hBF800000, 3'b001));
    vecs.push_back(mk("pos_rup",     48'h400000400000, 10'sd127, 1'b0, RUP, 32'h3F800001, 3'b001));
    vecs.push_back(mk("pos_rdn",     48'h400000400000, 10'sd127, 1'b0, RDN, 32'h3F800000, 3'b001));
    vecs.push_back(mk("carry_rne",   48'hFFFFFF800000, 10'sd127, 1'b0, RNE, 32'h40800000, 3'b001));
    vecs.push_back(mk("carry_rtz",   48'hFFFFFF800000, 10'sd127, 1'b0, RTZ, 32'h407FFFFF, 3'b001));
    vecs.push_back(mk("sub_to_norm", 48'hFFFFFF800000, -10'sd1,  1'b0, RNE, 32'h00800000, 3'b011));
    vecs.push_back(mk("sub_no_rnd",  48'hFFFFFF800000, -10'sd1,  1'b0, RTZ, 32'h007FFFFF, 3'b011));
    vecs.push_back(mk("carry_of",    48'hFFFFFF800000, 10'sd253, 1'b0, RNE, 32'h7F800000, 3'b101));
    vecs.push_back(mk("carry_no_of", 48'hFFFFFF800000, 10'sd253, 1'b0, RTZ, 32'h7F7FFFFF, 3'b001));

    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_sig = '0; in_rm = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset:out_valid", 64'(out_valid), 64'(0));
    check("reset:out_result", 64'(out_result), 64'(0));
    check("reset:out_flags", 64'(out_flags), 64'(0));
    rst = 1'b0;
    #1;
    check("reset:in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;

    foreach (vecs[i]) send_one(vecs[i]);

    // Four back-to-back beats against a stalled sink.
    bp[0] = mk("bp0", 48'h400000000000, 10'sd127, 1'b0, RNE, 32'h3F800000, 3'b000);
    bp[1] = mk("bp1", 48'h400000000000, 10'sd128, 1'b0, RNE, 32'h40000000, 3'b000);
    bp[2] = mk("bp2", 48'h400000000000, 10'sd129, 1'b0, RNE, 32'h40800000, 3'b000);
    bp[3] = mk("bp3", 48'h400000000000, 10'sd130, 1'b0, RNE, 32'h41000000, 3'b000);
    k = 0; got = 0;
    foreach (out_cyc[i]) out_cyc[i] = 0;
    for (int c = 0; c < 20; c++) begin
      out_ready = (c >= 6);
      if (k < 4) begin
        drive(bp[k]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c == 0) check("bp:ready_idle", 64'(in_ready), 64'(1));
      if (c == 2) begin
        check("bp:ready_drop", 64'(in_ready), 64'(0));
        check("bp:valid_held", 64'(out_valid), 64'(1));
      end
      if (out_valid && !out_ready) begin
        check("bp:stall_result", 64'(out_result), 64'(bp[0].res));
        check("bp:stall_flags", 64'(out_flags), 64'(bp[0].flags));
      end
      if (out_valid && out_ready) begin
        if (got < 4) begin
          check({bp[got].name, ":result"}, 64'(out_result), 64'(bp[got].res));
          check({bp[got].name, ":flags"}, 64'(out_flags), 64'(bp[got].flags));
          $display("bp  beat %0d cycle %0d res=%h flags=%b", got, c, out_result, out_flags);
          out_cyc[got] = c;
        end else begin
          check("bp:extra_beat", 64'(1), 64'(0));
        end
        got++;
      end
      if (in_valid && in_ready) k++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp:beats_out", 64'(got), 64'(4));
    check("bp:no_gaps", 64'(out_cyc[3] - out_cyc[0]), 64'(3));

    // Two beats in flight when reset strikes.
    out_ready = 1'b0;
    drive(bp[2]); in_valid = 1'b1;
    @(posedge clk); #1;
    drive(bp[3]);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rst:pre_valid", 64'(out_valid), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("rst:async_valid", 64'(out_valid), 64'(0));
    check("rst:async_result", 64'(out_result), 64'(0));
    check("rst:async_flags", 64'(out_flags), 64'(0));
    $display("rst asserted mid-stream, out_valid=%b", out_valid);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst:in_ready", 64'(in_ready), 64'(1));
    out_ready = 1'b1;
    ghosts = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_valid) ghosts++;
    end
    check("rst:no_ghost", 64'(ghosts), 64'(0));
    send_one(mk("post_rst", 48'h900000000000, 10'sd127, 1'b0, RNE, 32'h40100000, 3'b000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
